// File: rtl/port_pkg.sv
// Shared types and default widths for the port arbiter slice.
package port_pkg;

   localparam int PORT_ROZM_DATA_DEF = 8;
   localparam int PORT_LICZBA_DEF    = 3;

   typedef enum logic [1:0] {
      WR_DDR  = 2'b00,
      WR_PORT = 2'b01,
      RD_PIN  = 2'b10,
      NOP     = 2'b11
   } port_op_t;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      ISSUE   = 2'b01,
      RD_WAIT = 2'b10
   } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester picker: round-robin or fixed priority to requester 0,
// with a last-winner flop that updates whenever a grant is taken.
module rr_arb2 #(
   parameter int PRIO_MODE = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       take,
   output logic       win,
   output logic       any
);

   logic last;

   always_comb begin
      any = |req;
      win = 1'b0;
      if (req == 2'b11)
         win = (PRIO_MODE == 1) ? 1'b0 : ~last;
      else
         win = req[1];
   end

   // Resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         last <= 1'b1;
      else if (take && any)
         last <= win;
   end

endmodule

// File: rtl/port_arbiter.sv
// Serialises DDR/PORT writes and PIN reads from two requesters onto one
// GPIO port register file; one transaction in flight at a time.
//
//   state   | meaning
//   IDLE    | waiting; grants a winner and latches its request fields
//   ISSUE   | drives selects/strobe for the latched op
//   RD_WAIT | captures PIN data and pulses rvalid to the reader
module port_arbiter
   import port_pkg::*;
#(
   parameter int Port_rozm_data = PORT_ROZM_DATA_DEF,
   parameter int Port_liczba    = PORT_LICZBA_DEF,
   parameter int NR_W           = $clog2(Port_liczba),
   parameter int PRIO_MODE      = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [1:0]                req_i,
   input  logic [1:0]                op_0,
   input  logic [1:0]                op_1,
   input  logic [NR_W-1:0]           nr_0,
   input  logic [NR_W-1:0]           nr_1,
   input  logic [Port_rozm_data-1:0] dane_0,
   input  logic [Port_rozm_data-1:0] dane_1,
   output logic [1:0]                gnt_o,
   output logic [1:0]                rvalid_o,
   output logic [Port_rozm_data-1:0] rdata_o,
   output logic [Port_rozm_data-1:0] dane,
   output logic [NR_W-1:0]           nr_P_DDRx,
   output logic [NR_W-1:0]           nr_P_PORTx,
   output logic [NR_W-1:0]           nr_P_PINx,
   output logic                      wr_DDRx,
   output logic                      wr_PORTx,
   input  logic [Port_rozm_data-1:0] out
);

   arb_state_t                state;
   port_op_t                  op_q;
   logic [NR_W-1:0]           nr_q;
   logic [Port_rozm_data-1:0] dane_q;
   logic                      w_q;
   logic                      win;
   logic                      any;
   logic                      take;

   assign take = (state == IDLE);

   rr_arb2 #(
      .PRIO_MODE(PRIO_MODE)
   ) u_arb (
      .clk  (clk),
      .rst  (rst),
      .req  (req_i),
      .take (take),
      .win  (win),
      .any  (any)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         op_q       <= WR_DDR;
         nr_q       <= '0;
         dane_q     <= '0;
         w_q        <= 1'b0;
         gnt_o      <= '0;
         rvalid_o   <= '0;
         rdata_o    <= '0;
         dane       <= '0;
         nr_P_DDRx  <= '0;
         nr_P_PORTx <= '0;
         nr_P_PINx  <= '0;
         wr_DDRx    <= 1'b0;
         wr_PORTx   <= 1'b0;
      end else begin
         // Pulses and strobes last one cycle; selects and data hold.
         gnt_o    <= '0;
         rvalid_o <= '0;
         wr_DDRx  <= 1'b0;
         wr_PORTx <= 1'b0;
         case (state)
            IDLE: begin
               if (any) begin
                  gnt_o  <= win ? 2'b10 : 2'b01;
                  w_q    <= win;
                  op_q   <= port_op_t'(win ? op_1 : op_0);
                  nr_q   <= win ? nr_1 : nr_0;
                  dane_q <= win ? dane_1 : dane_0;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               case (op_q)
                  WR_DDR: begin
                     nr_P_DDRx <= nr_q;
                     dane      <= dane_q;
                     wr_DDRx   <= 1'b1;
                     state     <= IDLE;
                  end
                  WR_PORT: begin
                     nr_P_PORTx <= nr_q;
                     dane       <= dane_q;
                     wr_PORTx   <= 1'b1;
                     state      <= IDLE;
                  end
                  RD_PIN: begin
                     nr_P_PINx <= nr_q;
                     state     <= RD_WAIT;
                  end
                  default: state <= IDLE;
               endcase
            end
            RD_WAIT: begin
               rdata_o  <= out;
               rvalid_o <= w_q ? 2'b10 : 2'b01;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_port_arbiter.sv
// Bench for port_arbiter: round-robin and fixed-priority instances driven
// side by side, checked each cycle against a transaction-level model.
module tb_port_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0] req_s  [2];
   logic [1:0] op0_s  [2];
   logic [1:0] op1_s  [2];
   logic [1:0] nr0_s  [2];
   logic [1:0] nr1_s  [2];
   logic [7:0] d0_s   [2];
   logic [7:0] d1_s   [2];
   logic [1:0] gnt_s  [2];
   logic [1:0] rv_s   [2];
   logic [7:0] rdata_s[2];
   logic [7:0] dane_s [2];
   logic [1:0] nrd_s  [2];
   logic [1:0] nrp_s  [2];
   logic [1:0] nri_s  [2];
   logic       wd_s   [2];
   logic       wp_s   [2];
   logic [7:0] out_s  [2];

   logic [7:0] pins  [2][3];
   logic [7:0] ddr_r [2][3];
   logic [7:0] prt_r [2][3];

   port_arbiter #(.Port_rozm_data(8), .Port_liczba(3), .NR_W(2), .PRIO_MODE(0)) dut_rr (
      .clk(clk), .rst(rst), .req_i(req_s[0]), .op_0(op0_s[0]), .op_1(op1_s[0]),
      .nr_0(nr0_s[0]), .nr_1(nr1_s[0]), .dane_0(d0_s[0]), .dane_1(d1_s[0]),
      .gnt_o(gnt_s[0]), .rvalid_o(rv_s[0]), .rdata_o(rdata_s[0]), .dane(dane_s[0]),
      .nr_P_DDRx(nrd_s[0]), .nr_P_PORTx(nrp_s[0]), .nr_P_PINx(nri_s[0]),
      .wr_DDRx(wd_s[0]), .wr_PORTx(wp_s[0]), .out(out_s[0]));

   port_arbiter #(.Port_rozm_data(8), .Port_liczba(3), .NR_W(2), .PRIO_MODE(1)) dut_fp (
      .clk(clk), .rst(rst), .req_i(req_s[1]), .op_0(op0_s[1]), .op_1(op1_s[1]),
      .nr_0(nr0_s[1]), .nr_1(nr1_s[1]), .dane_0(d0_s[1]), .dane_1(d1_s[1]),
      .gnt_o(gnt_s[1]), .rvalid_o(rv_s[1]), .rdata_o(rdata_s[1]), .dane(dane_s[1]),
      .nr_P_DDRx(nrd_s[1]), .nr_P_PORTx(nrp_s[1]), .nr_P_PINx(nri_s[1]),
      .wr_DDRx(wd_s[1]), .wr_PORTx(wp_s[1]), .out(out_s[1]));

   function automatic logic [7:0] pin_of(input int m, input logic [1:0] nr);
      case (nr)
         2'd0:    return pins[m][0];
         2'd1:    return pins[m][1];
         2'd2:    return pins[m][2];
         default: return 8'h00;
      endcase
   endfunction

   always_comb begin
      for (int m = 0; m < 2; m++) out_s[m] = pin_of(m, nri_s[m]);
   end

   // Behavioural port register file fed by the arbiter's strobes.
   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (wd_s[m] && nrd_s[m] < 2'd3) ddr_r[m][int'(nrd_s[m])] <= dane_s[m];
         if (wp_s[m] && nrp_s[m] < 2'd3) prt_r[m][int'(nrp_s[m])] <= dane_s[m];
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      int         cyc;
      int         m;
      int         kind;   // 0 gnt, 1 wr_ddr, 2 wr_port, 3 pin select, 4 rvalid
      logic       w;
      logic [1:0] nr;
      logic [7:0] d;
   } ev_t;

   ev_t        evq[$];
   int         cyc;
   int         free_edge[2];
   logic       last_w[2];
   logic [1:0] e_gnt[2], e_rv[2];
   logic       e_wd[2], e_wp[2];
   logic [1:0] e_nrd[2], e_nrp[2], e_nri[2];
   logic [7:0] e_dane[2], e_rdata[2];
   int         stim_mode;
   int         vectors;
   int         miscompares;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_ev(input int c, input int m, input int kind, input logic w,
                          input logic [1:0] nr, input logic [7:0] d);
      ev_t e;
      e.cyc = c; e.m = m; e.kind = kind; e.w = w; e.nr = nr; e.d = d;
      evq.push_back(e);
   endtask

   task automatic model_reset();
      evq.delete();
      for (int m = 0; m < 2; m++) begin
         free_edge[m] = 0;
         last_w[m]    = 1'b1;
         e_gnt[m] = '0; e_rv[m] = '0; e_wd[m] = 1'b0; e_wp[m] = 1'b0;
         e_nrd[m] = '0; e_nrp[m] = '0; e_nri[m] = '0;
         e_dane[m] = '0; e_rdata[m] = '0;
         req_s[m] = '0;
      end
   endtask

   // Decide who wins the coming edge and schedule that transaction's effects.
   task automatic arbitrate();
      logic       w;
      logic [1:0] opv, nrv;
      logic [7:0] dv;
      int         k;
      for (int m = 0; m < 2; m++) begin
         if (rst && (cyc + 1 >= free_edge[m]) && req_s[m] != 2'b00) begin
            if (req_s[m] == 2'b11) w = (m == 1) ? 1'b0 : ~last_w[m];
            else                   w = req_s[m][1];
            last_w[m] = w;
            k   = cyc + 1;
            opv = w ? op1_s[m] : op0_s[m];
            nrv = w ? nr1_s[m] : nr0_s[m];
            dv  = w ? d1_s[m]  : d0_s[m];
            push_ev(k, m, 0, w, nrv, dv);
            case (opv)
               2'b00: push_ev(k + 1, m, 1, w, nrv, dv);
               2'b01: push_ev(k + 1, m, 2, w, nrv, dv);
               2'b10: begin
                  push_ev(k + 1, m, 3, w, nrv, dv);
                  push_ev(k + 2, m, 4, w, nrv, dv);
               end
               default: ;
            endcase
            free_edge[m] = k + ((opv == 2'b10) ? 3 : 2);
         end
      end
   endtask

   task automatic apply_model();
      ev_t keep[$];
      for (int m = 0; m < 2; m++) begin
         e_gnt[m] = '0; e_rv[m] = '0; e_wd[m] = 1'b0; e_wp[m] = 1'b0;
      end
      foreach (evq[i]) begin
         if (evq[i].cyc == cyc) begin
            case (evq[i].kind)
               0: e_gnt[evq[i].m] = evq[i].w ? 2'b10 : 2'b01;
               1: begin
                  e_wd[evq[i].m] = 1'b1; e_nrd[evq[i].m] = evq[i].nr; e_dane[evq[i].m] = evq[i].d;
               end
               2: begin
                  e_wp[evq[i].m] = 1'b1; e_nrp[evq[i].m] = evq[i].nr; e_dane[evq[i].m] = evq[i].d;
               end
               3: e_nri[evq[i].m] = evq[i].nr;
               default: begin
                  e_rv[evq[i].m]    = evq[i].w ? 2'b10 : 2'b01;
                  e_rdata[evq[i].m] = pin_of(evq[i].m, e_nri[evq[i].m]);
               end
            endcase
         end else begin
            keep.push_back(evq[i]);
         end
      end
      evq = keep;
   endtask

   task automatic compare(input string where);
      for (int m = 0; m < 2; m++) begin
         check_val($sformatf("%s_pulses%0d", where, m),
                   32'({gnt_s[m], rv_s[m], wd_s[m], wp_s[m]}),
                   32'({e_gnt[m], e_rv[m], e_wd[m], e_wp[m]}));
         check_val($sformatf("%s_hold%0d", where, m),
                   32'({nrd_s[m], nrp_s[m], nri_s[m], dane_s[m], rdata_s[m]}),
                   32'({e_nrd[m], e_nrp[m], e_nri[m], e_dane[m], e_rdata[m]}));
      end
   endtask

   task automatic new_req(input int m, input int r, input logic [1:0] op,
                          input logic [1:0] nr, input logic [7:0] d);
      if (r == 0) begin op0_s[m] = op; nr0_s[m] = nr; d0_s[m] = d; end
      else        begin op1_s[m] = op; nr1_s[m] = nr; d1_s[m] = d; end
      req_s[m][r] = 1'b1;
   endtask

   task automatic step();
      arbitrate();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      apply_model();
      compare("cyc");
      for (int m = 0; m < 2; m++) begin
         for (int r = 0; r < 2; r++) begin
            if (e_gnt[m][r]) req_s[m][r] = 1'b0;
            if (!req_s[m][r] &&
                (stim_mode == 2 || (stim_mode == 1 && $urandom_range(0, 1) == 1)))
               new_req(m, r, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       8'($urandom_range(0, 255)));
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   initial begin
      rst = 1'b1;
      cyc = 0; vectors = 0; miscompares = 0; stim_mode = 0;
      for (int m = 0; m < 2; m++) begin
         op0_s[m] = '0; op1_s[m] = '0; nr0_s[m] = '0; nr1_s[m] = '0;
         d0_s[m] = '0; d1_s[m] = '0;
         for (int i = 0; i < 3; i++) pins[m][i] = 8'h00;
      end
      model_reset();
      #2 rst = 1'b0;
      #1 compare("reset");
      run(2);
      rst = 1'b1;

      // WR_DDR to port C from requester 0
      for (int m = 0; m < 2; m++) new_req(m, 0, 2'b00, 2'd2, 8'hFF);
      run(4);
      for (int m = 0; m < 2; m++) check_val($sformatf("ddr_c%0d", m), 32'(ddr_r[m][2]), 32'h0000_00FF);

      // RD_PIN port A from requester 1
      for (int m = 0; m < 2; m++) begin
         pins[m][0] = 8'h01;
         new_req(m, 1, 2'b10, 2'd0, 8'h00);
      end
      run(5);

      // Both requesting continuously: alternation vs fixed priority
      stim_mode = 2;
      run(14);
      stim_mode = 0;
      run(10);

      // Read then write back-to-back from different requesters
      for (int m = 0; m < 2; m++) new_req(m, 0, 2'b10, 2'd0, 8'h00);
      step();
      for (int m = 0; m < 2; m++) new_req(m, 1, 2'b01, 2'd2, 8'h05);
      run(8);
      for (int m = 0; m < 2; m++) check_val($sformatf("port_c%0d", m), 32'(prt_r[m][2]), 32'h0000_0005);

      // NOP is granted but does nothing else
      for (int m = 0; m < 2; m++) new_req(m, 0, 2'b11, 2'd1, 8'hAA);
      run(4);

      // Reset while a read sits in RD_WAIT
      for (int m = 0; m < 2; m++) begin
         pins[m][1] = 8'h5A;
         new_req(m, 0, 2'b10, 2'd1, 8'h00);
      end
      run(2);
      rst = 1'b0;
      model_reset();
      #1 compare("midrst");
      run(3);
      rst = 1'b1;
      for (int m = 0; m < 2; m++) new_req(m, 1, 2'b10, 2'd1, 8'h00);
      run(5);

      // Randomised traffic, including out-of-range port indices
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < 3; i++) pins[m][i] = 8'($urandom_range(0, 255));
      stim_mode = 1;
      run(600);
      stim_mode = 0;
      run(12);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
